// File: rtl/p_mul_pkg.sv
// Shared encodings, widths and payload types for the p_mul issue/response sequencer.
package p_mul_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned RD_W     = 5;
  localparam int unsigned OP_W     = 2;
  localparam int unsigned PW_W     = 3;
  localparam int unsigned PW_OH_W  = 5;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned RSPQ_DEPTH = 2;

  localparam logic [OP_W-1:0] OP_MUL_L   = 2'b00;
  localparam logic [OP_W-1:0] OP_MUL_H   = 2'b01;
  localparam logic [OP_W-1:0] OP_CLMUL_L = 2'b10;
  localparam logic [OP_W-1:0] OP_CLMUL_H = 2'b11;

  localparam logic [PW_W-1:0] PW_32 = 3'd0;
  localparam logic [PW_W-1:0] PW_16 = 3'd1;
  localparam logic [PW_W-1:0] PW_8  = 3'd2;
  localparam logic [PW_W-1:0] PW_4  = 3'd3;
  localparam logic [PW_W-1:0] PW_2  = 3'd4;
  localparam logic [PW_W-1:0] PW_MAX_LEGAL = 3'd4;

  localparam logic [PW_OH_W-1:0] PW_OH_32 = 5'b00001;
  localparam logic [PW_OH_W-1:0] PW_OH_16 = 5'b00010;
  localparam logic [PW_OH_W-1:0] PW_OH_8  = 5'b00100;
  localparam logic [PW_OH_W-1:0] PW_OH_4  = 5'b01000;
  localparam logic [PW_OH_W-1:0] PW_OH_2  = 5'b10000;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  // Response queue entry: 38 bits.
  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] data;
    logic            err;
  } rsp_t;

  function automatic logic [PW_OH_W-1:0] pw_onehot(input logic [PW_W-1:0] pw);
    return PW_OH_W'(1) << pw;
  endfunction

endpackage

// File: rtl/p_mul_seq_if.sv
// Request, p_mul and response channels of the sequencer; slave = sequencer side.
interface p_mul_seq_if;
  import p_mul_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [OP_W-1:0]     req_op;
  logic [PW_W-1:0]     req_pw;
  logic [RD_W-1:0]     req_rd;
  logic [XLEN-1:0]     req_rs1;
  logic [XLEN-1:0]     req_rs2;

  logic                mul_valid;
  logic                mul_ready;
  logic                mul_l;
  logic                mul_h;
  logic                clmul;
  logic [PW_OH_W-1:0]  mul_pw;
  logic [XLEN-1:0]     mul_crs1;
  logic [XLEN-1:0]     mul_crs2;
  logic [XLEN-1:0]     mul_result;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [RD_W-1:0]     rsp_rd;
  logic [XLEN-1:0]     rsp_data;
  logic                rsp_err;

  modport slave (
    input  req_valid, req_op, req_pw, req_rd, req_rs1, req_rs2,
    output req_ready,
    output mul_valid, mul_l, mul_h, clmul, mul_pw, mul_crs1, mul_crs2,
    input  mul_ready, mul_result,
    output rsp_valid, rsp_rd, rsp_data, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_op, req_pw, req_rd, req_rs1, req_rs2,
    input  req_ready,
    input  mul_valid, mul_l, mul_h, clmul, mul_pw, mul_crs1, mul_crs2,
    output mul_ready, mul_result,
    input  rsp_valid, rsp_rd, rsp_data, rsp_err,
    output rsp_ready
  );

endinterface

// File: rtl/p_mul_seq_rspq.sv
// Two-entry response FIFO; the head lives in its own register so rsp_* come straight from flops.
module p_mul_seq_rspq
  import p_mul_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             enq_i,
  input  rsp_t             enq_data_i,
  input  logic             deq_i,
  output logic [CNT_W-1:0] count_o,
  output logic             valid_o,
  output rsp_t             head_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             valid_q, valid_d;
  rsp_t             head_q, head_d;
  rsp_t             tail_q, tail_d;
  logic             deq;

  assign deq = deq_i && valid_q;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (count_q)
      2'd0: begin
        if (enq_i) begin
          head_d  = enq_data_i;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (enq_i && deq) begin
          head_d = enq_data_i;
        end else if (enq_i) begin
          tail_d  = enq_data_i;
          count_d = 2'd2;
        end else if (deq) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        // Only one multiply is in flight, so an enqueue here always pairs with a dequeue.
        if (deq) begin
          head_d = tail_q;
          if (enq_i) begin
            tail_d = enq_data_i;
          end else begin
            count_d = 2'd1;
          end
        end
      end
      default: count_d = '0;
    endcase
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      count_q <= count_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign count_o = count_q;
  assign valid_o = valid_q;
  assign head_o  = head_q;

endmodule

// File: rtl/p_mul_seq.sv
// Issue/response sequencer in front of p_mul: decodes requests, holds operands over the
// p_mul handshake, traps illegal pack widths and buffers results for writeback.
module p_mul_seq
  import p_mul_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  p_mul_seq_if.slave bus
);

  state_e             state_q;
  logic               mul_valid_q;
  logic               mul_l_q;
  logic               mul_h_q;
  logic               clmul_q;
  logic [PW_OH_W-1:0] mul_pw_q;
  logic [XLEN-1:0]    crs1_q;
  logic [XLEN-1:0]    crs2_q;
  logic [RD_W-1:0]    rd_q;

  logic [CNT_W-1:0]   rspq_count;
  logic               rspq_valid;
  rsp_t               rspq_head;
  logic               pw_legal;
  logic               accept;
  logic               mul_fire;
  logic               enq;
  rsp_t               enq_entry;

  assign pw_legal = (bus.req_pw <= PW_MAX_LEGAL);
  // Gated by reset so no request can be taken on the reset cycle itself.
  assign bus.req_ready = !reset && (state_q == ST_IDLE) && (rspq_count < CNT_W'(RSPQ_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;
  assign mul_fire      = mul_valid_q && bus.mul_ready;

  always_comb begin
    enq       = 1'b0;
    enq_entry = '0;
    if (accept && !pw_legal) begin
      enq           = 1'b1;
      enq_entry.rd  = bus.req_rd;
      enq_entry.err = 1'b1;
    end else if (mul_fire) begin
      enq            = 1'b1;
      enq_entry.rd   = rd_q;
      enq_entry.data = bus.mul_result;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      mul_valid_q <= 1'b0;
      mul_l_q     <= 1'b0;
      mul_h_q     <= 1'b0;
      clmul_q     <= 1'b0;
      mul_pw_q    <= '0;
      crs1_q      <= '0;
      crs2_q      <= '0;
      rd_q        <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept && pw_legal) begin
            state_q     <= ST_BUSY;
            mul_valid_q <= 1'b1;
            mul_l_q     <= (bus.req_op == OP_MUL_L);
            mul_h_q     <= bus.req_op[0];
            clmul_q     <= bus.req_op[1];
            mul_pw_q    <= pw_onehot(bus.req_pw);
            crs1_q      <= bus.req_rs1;
            crs2_q      <= bus.req_rs2;
            rd_q        <= bus.req_rd;
          end
        end
        ST_BUSY: begin
          if (bus.mul_ready) begin
            state_q     <= ST_IDLE;
            mul_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  p_mul_seq_rspq u_rspq (
    .clock      (clock),
    .reset      (reset),
    .enq_i      (enq),
    .enq_data_i (enq_entry),
    .deq_i      (bus.rsp_ready),
    .count_o    (rspq_count),
    .valid_o    (rspq_valid),
    .head_o     (rspq_head)
  );

  assign bus.mul_valid = mul_valid_q;
  assign bus.mul_l     = mul_l_q;
  assign bus.mul_h     = mul_h_q;
  assign bus.clmul     = clmul_q;
  assign bus.mul_pw    = mul_pw_q;
  assign bus.mul_crs1  = crs1_q;
  assign bus.mul_crs2  = crs2_q;

  assign bus.rsp_valid = rspq_valid;
  assign bus.rsp_rd    = rspq_head.rd;
  assign bus.rsp_data  = rspq_head.data;
  assign bus.rsp_err   = rspq_head.err;

endmodule
